// File: rtl/lut_cluster_pkg.sv
// Shared constants and types for the LUT cluster: per-BLE configuration layout
// and the configuration state machine encoding.
package lut_cluster_pkg;

    // One BLE's configuration: truth table, then regsel, then FF init value.
    function automatic int ble_cfg_w(input int k);
        return int'((32'd1 << k) + 32'd2);
    endfunction

    function automatic int regsel_bit(input int k);
        return int'(32'd1 << k);
    endfunction

    function automatic int init_bit(input int k);
        return int'((32'd1 << k) + 32'd1);
    endfunction

    localparam int TT_LSB = 0;

    typedef enum logic [0:0] {
        UNCONFIGURED = 1'b0,
        ACTIVE       = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/lut_cluster_if.sv
// Data and configuration-scan signals of one LUT cluster tile.
interface lut_cluster_if #(
    parameter int K = 2,
    parameter int N = 2
);
    logic [N*K-1:0] I;
    logic           ce;
    logic           cfg_shift;
    logic           cfg_in;
    logic           cfg_commit;
    logic           cfg_out;
    logic           cfg_ready;
    logic           configured;
    logic           cfg_err;
    logic [N-1:0]   Z;

    modport master (
        output I, ce, cfg_shift, cfg_in, cfg_commit,
        input  cfg_out, cfg_ready, configured, cfg_err, Z
    );

    modport slave (
        input  I, ce, cfg_shift, cfg_in, cfg_commit,
        output cfg_out, cfg_ready, configured, cfg_err, Z
    );
endinterface

// File: rtl/lut_cluster_ble.sv
// Basic logic element: K-input LUT, optional output FF with clock enable and
// load-on-commit of the initial value.
module lut_ble
    import lut_cluster_pkg::*;
#(
    parameter int K = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2**K-1:0] tt_i,
    input  logic            regsel_i,
    input  logic            en_i,
    input  logic            load_i,
    input  logic            init_i,
    input  logic            ce_i,
    input  logic [K-1:0]    in_i,
    output logic            z_o
);
    logic lut_s;
    logic ff_q;
    logic ff_d;

    assign lut_s = tt_i[in_i];

    // FF next state: a commit loads init, otherwise capture the LUT when enabled.
    always_comb begin
        ff_d = ff_q;
        if (load_i) begin
            ff_d = init_i;
        end else if (en_i && ce_i) begin
            ff_d = lut_s;
        end else begin
            ff_d = ff_q;
        end
    end

    // Output flip-flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            ff_q <= 1'b0;
        end else begin
            ff_q <= ff_d;
        end
    end

    // Output select; forced low until the cluster holds a valid configuration.
    always_comb begin
        z_o = 1'b0;
        if (!en_i) begin
            z_o = 1'b0;
        end else if (regsel_i) begin
            z_o = ff_q;
        end else begin
            z_o = lut_s;
        end
    end
endmodule

// File: rtl/lut_cluster.sv
// Cluster of N BLEs with a daisy-chainable serial shadow configuration that is
// committed atomically to the active configuration.
module lut_cluster
    import lut_cluster_pkg::*;
#(
    parameter int K = 2,
    parameter int N = 2
) (
    input  logic          clk,
    input  logic          reset,
    lut_cluster_if.slave  bus
);
    localparam int BLE_CFG_W = ble_cfg_w(K);
    localparam int CFG_W     = N * BLE_CFG_W;
    localparam int CNT_W     = $clog2(CFG_W + 1);
    // Active copy drops the init bits: they only matter at the commit edge.
    localparam int ACT_W     = regsel_bit(K) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CFG_W-1:0]   shadow_q, shadow_d;
    logic [N*ACT_W-1:0] active_q, active_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    cfg_state_t         state_q;
    logic               err_q;
    logic               ready_s;
    logic               accept_s;
    logic               configured_s;

    assign ready_s      = (cnt_q == CNT_FULL);
    assign accept_s     = bus.cfg_commit && ready_s;
    assign configured_s = (state_q == ACTIVE);

    // Next state of the scan chain, bit counter and active configuration.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        if (bus.cfg_shift) begin
            shadow_d = {shadow_q[CFG_W-2:0], bus.cfg_in};
        end else begin
            shadow_d = shadow_q;
        end
        if (accept_s) begin
            for (int i = 0; i < N; i++) begin
                active_d[i*ACT_W +: ACT_W] = shadow_q[i*BLE_CFG_W + TT_LSB +: ACT_W];
            end
            cnt_d = bus.cfg_shift ? CNT_ONE : {CNT_W{1'b0}};
        end else if (bus.cfg_shift && !ready_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Configuration datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= {CFG_W{1'b0}};
            active_q <= {(N*ACT_W){1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
        end
    end

    // Configuration state machine and registered commit-reject pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNCONFIGURED;
            err_q   <= 1'b0;
        end else begin
            err_q <= bus.cfg_commit && !ready_s;
            case (state_q)
                UNCONFIGURED: state_q <= accept_s ? ACTIVE : UNCONFIGURED;
                ACTIVE:       state_q <= ACTIVE;
                default:      state_q <= UNCONFIGURED;
            endcase
        end
    end

    assign bus.cfg_out    = shadow_q[CFG_W-1];
    assign bus.cfg_ready  = ready_s;
    assign bus.configured = configured_s;
    assign bus.cfg_err    = err_q;

    for (genvar g = 0; g < N; g++) begin : g_ble
        lut_ble #(.K(K)) u_ble (
            .clk      (clk),
            .reset    (reset),
            .tt_i     (active_q[g*ACT_W + TT_LSB +: 2**K]),
            .regsel_i (active_q[g*ACT_W + regsel_bit(K)]),
            .en_i     (configured_s),
            .load_i   (accept_s),
            .init_i   (shadow_q[g*BLE_CFG_W + init_bit(K)]),
            .ce_i     (bus.ce),
            .in_i     (bus.I[g*K +: K]),
            .z_o      (bus.Z[g])
        );
    end
endmodule

// File: tb/tb_lut_cluster.sv
// Directed bench for lut_cluster (K=2, N=2): two daisy-chained instances
// sharing control, data inputs and reset.
module tb_lut_cluster;
    localparam int K = 2;
    localparam int N = 2;
    // BLE1 = XOR registered init 1, BLE0 = AND combinational.
    localparam logic [11:0] CFG_A = 12'b110110_001000;
    // BLE1 = OR registered init 0, BLE0 = NOR combinational init 1.
    localparam logic [11:0] CFG_B = 12'b011110_100001;
    // BLE1 = constant 0 combinational, BLE0 = OR combinational.
    localparam logic [11:0] CFG_C = 12'b000000_001110;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lut_cluster_if #(.K(K), .N(N)) u_if0 ();
    lut_cluster_if #(.K(K), .N(N)) u_if1 ();

    assign u_if1.I          = u_if0.I;
    assign u_if1.ce         = u_if0.ce;
    assign u_if1.cfg_shift  = u_if0.cfg_shift;
    assign u_if1.cfg_commit = u_if0.cfg_commit;
    assign u_if1.cfg_in     = u_if0.cfg_out;

    lut_cluster #(.K(K), .N(N)) u_dut0 (.clk(clk), .reset(reset), .bus(u_if0.slave));
    lut_cluster #(.K(K), .N(N)) u_dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [23:0] stream;
        reset            = 1'b1;
        u_if0.I          = 4'b0000;
        u_if0.ce         = 1'b0;
        u_if0.cfg_shift  = 1'b0;
        u_if0.cfg_in     = 1'b0;
        u_if0.cfg_commit = 1'b0;

        // 1. reset
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_eq("rst_z", 32'(u_if0.Z), 32'd0);
        check_eq("rst_configured", 32'(u_if0.configured), 32'd0);
        check_eq("rst_ready", 32'(u_if0.cfg_ready), 32'd0);
        check_eq("rst_cfg_out", 32'(u_if0.cfg_out), 32'd0);
        check_eq("rst_err", 32'(u_if0.cfg_err), 32'd0);

        // 2. shift CFG_A MSB first, then commit
        for (int j = 11; j >= 0; j--) begin
            u_if0.cfg_shift = 1'b1;
            u_if0.cfg_in    = CFG_A[j];
            tick();
            if (j == 1) check_eq("ready_after_11", 32'(u_if0.cfg_ready), 32'd0);
        end
        check_eq("ready_after_12", 32'(u_if0.cfg_ready), 32'd1);
        u_if0.cfg_shift  = 1'b0;
        u_if0.cfg_commit = 1'b1;
        tick();
        u_if0.cfg_commit = 1'b0;
        u_if0.I          = 4'b0011;
        #1;
        check_eq("commit_configured", 32'(u_if0.configured), 32'd1);
        check_eq("commit_ready_clr", 32'(u_if0.cfg_ready), 32'd0);
        check_eq("commit_z_i0011", 32'(u_if0.Z), 32'b11);
        u_if0.I = 4'b0001;
        #1;
        check_eq("commit_z_i0001", 32'(u_if0.Z), 32'b10);

        // 3. combinational AND immediately, registered XOR one edge later
        u_if0.I  = 4'b1111;
        u_if0.ce = 1'b1;
        #1;
        check_eq("and_comb", 32'(u_if0.Z), 32'b11);
        tick();
        check_eq("xor_reg", 32'(u_if0.Z), 32'b01);
        u_if0.ce = 1'b0;
        u_if0.I  = 4'b0111;
        tick();
        check_eq("ce0_hold", 32'(u_if0.Z), 32'b01);

        // 4. premature commit is rejected
        for (int j = 0; j < 5; j++) begin
            u_if0.cfg_shift = 1'b1;
            u_if0.cfg_in    = 1'b1;
            tick();
        end
        u_if0.cfg_shift  = 1'b0;
        u_if0.cfg_commit = 1'b1;
        tick();
        u_if0.cfg_commit = 1'b0;
        check_eq("err_pulse", 32'(u_if0.cfg_err), 32'd1);
        check_eq("err_configured", 32'(u_if0.configured), 32'd1);
        tick();
        check_eq("err_clear", 32'(u_if0.cfg_err), 32'd0);
        u_if0.I = 4'b0010;
        #1;
        check_eq("err_func_i0010", 32'(u_if0.Z), 32'b00);
        u_if0.I = 4'b0011;
        #1;
        check_eq("err_func_i0011", 32'(u_if0.Z), 32'b01);

        // 5. daisy chain: CFG_B lands in dut1, CFG_A in dut0
        stream = {CFG_B, CFG_A};
        for (int j = 0; j < 24; j++) begin
            u_if0.cfg_shift = 1'b1;
            u_if0.cfg_in    = stream[23-j];
            tick();
            if (j + 1 >= 12) check_eq("chain_cfg_out", 32'(u_if0.cfg_out), 32'(stream[23-(j+1-12)]));
        end
        u_if0.cfg_shift  = 1'b0;
        u_if0.cfg_commit = 1'b1;
        tick();
        u_if0.cfg_commit = 1'b0;
        u_if0.I          = 4'b0000;
        #1;
        check_eq("chain0_i0000", 32'(u_if0.Z), 32'b10);
        check_eq("chain1_i0000", 32'(u_if1.Z), 32'b01);
        check_eq("chain1_configured", 32'(u_if1.configured), 32'd1);
        u_if0.I = 4'b0001;
        #1;
        check_eq("chain0_i0001", 32'(u_if0.Z), 32'b10);
        check_eq("chain1_i0001", 32'(u_if1.Z), 32'b00);
        u_if0.I  = 4'b1100;
        u_if0.ce = 1'b1;
        tick();
        u_if0.ce = 1'b0;
        check_eq("chain0_reg", 32'(u_if0.Z), 32'b00);
        check_eq("chain1_reg", 32'(u_if1.Z), 32'b11);

        // 6. commit together with shift takes the pre-shift shadow
        for (int j = 11; j >= 0; j--) begin
            u_if0.cfg_shift = 1'b1;
            u_if0.cfg_in    = CFG_C[j];
            tick();
        end
        u_if0.cfg_in     = 1'b1;
        u_if0.cfg_commit = 1'b1;
        tick();
        u_if0.cfg_commit = 1'b0;
        u_if0.cfg_shift  = 1'b0;
        u_if0.I          = 4'b0000;
        #1;
        check_eq("cs_ready", 32'(u_if0.cfg_ready), 32'd0);
        check_eq("cs_z_i0000", 32'(u_if0.Z), 32'b00);
        u_if0.I = 4'b0001;
        #1;
        check_eq("cs_z_i0001", 32'(u_if0.Z), 32'b01);
        for (int j = 0; j < 11; j++) begin
            u_if0.cfg_shift = 1'b1;
            tick();
            if (j == 9) check_eq("cs_ready_after_10", 32'(u_if0.cfg_ready), 32'd0);
        end
        check_eq("cs_ready_after_11", 32'(u_if0.cfg_ready), 32'd1);
        check_eq("pre_rst_cfg_out", 32'(u_if0.cfg_out), 32'd1);

        // reset during shift and commit wins
        u_if0.I          = 4'b1111;
        u_if0.cfg_commit = 1'b1;
        reset            = 1'b1;
        tick();
        reset            = 1'b0;
        u_if0.cfg_shift  = 1'b0;
        u_if0.cfg_commit = 1'b0;
        #1;
        check_eq("mid_rst_z", 32'(u_if0.Z), 32'd0);
        check_eq("mid_rst_configured", 32'(u_if0.configured), 32'd0);
        check_eq("mid_rst_ready", 32'(u_if0.cfg_ready), 32'd0);
        check_eq("mid_rst_cfg_out", 32'(u_if0.cfg_out), 32'd0);
        check_eq("mid_rst_err", 32'(u_if0.cfg_err), 32'd0);
        check_eq("mid_rst_configured1", 32'(u_if1.configured), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
